// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared state encodings and default timing constants for the
//               stopwatch control block.
// Config      : none (STOPWATCH_CTRL_DEBOUNCE_EN is consumed by key_debounce)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // 10 ms at 50 MHz
  localparam int unsigned TICK_DIV_10MS    = 500000;
  // 20 ms of stable key level at 50 MHz
  localparam int unsigned DEBOUNCE_DEFAULT = 1000000;

endpackage : stopwatch_pkg

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Conditions one active-low push key: 2-flop synchroniser,
//               optional debounce filter, and a one-cycle press detector on
//               the debounced 1->0 transition.
// Config      : STOPWATCH_CTRL_DEBOUNCE_EN - defined: level changes only after
//               DEBOUNCE_CYCLES consecutive differing samples; undefined: the
//               synchroniser output is used directly, no counter is built.
// Ports       : clk      in  system clock
//               rst_n    in  asynchronous active-low reset
//               key_n    in  raw active-low key
//               pressed  out debounced level, 1 while the key is held
//               press    out one-cycle pulse on a debounced press
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  // Reset value 1: keys are treated as released while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter tallies consecutive samples that differ from the accepted
  // level; the DEBOUNCE_CYCLES-th one flips the level. Any agreeing sample
  // restarts the count, so it never exceeds DEBOUNCE_CYCLES-1.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign pressed = ~level;
  assign press   = prev_q & ~level;

endmodule : key_debounce

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch sequencing: key conditioning, IDLE/RUN/PAUSE state
//               machine, display freeze flag and count-enable tick prescaler.
// Config      : STOPWATCH_CTRL_DEBOUNCE_EN enables the key debounce filters.
// Ports       : clk, rst_n           clock, asynchronous active-low reset
//               key_reset            active-low key, clears the stopwatch
//               key_start_pause      active-low key, toggles counting
//               key_display_stop     active-low key, toggles display freeze
//               tick                 one-cycle count enable
//               clr                  one-cycle counter clear
//               disp_load            1 = display follows the counters
//               state[1:0]           00 IDLE, 01 RUN, 10 PAUSE
//               led[3:0]             {key held, frozen, PAUSE, RUN}
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV        = TICK_DIV_10MS,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_reset,
  input  logic       key_start_pause,
  input  logic       key_display_stop,
  output logic       tick,
  output logic       clr,
  output logic       disp_load,
  output logic [1:0] state,
  output logic [3:0] led
);

  if (TICK_DIV < 2) begin : g_cfg_check
    $error("stopwatch_ctrl: TICK_DIV must be >= 2");
  end

  localparam int unsigned        PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  // Key index: 0 reset, 1 start/pause, 2 display
  logic [2:0] keys_n;
  logic [2:0] key_pressed;
  logic [2:0] key_press;

  assign keys_n = {key_display_stop, key_start_pause, key_reset};

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n  (keys_n[gi]),
      .pressed(key_pressed[gi]),
      .press  (key_press[gi])
    );
  end

  state_t               state_q;
  state_t               state_d;
  logic                 freeze_q;
  logic                 freeze_d;
  logic [PRESC_W-1:0]   presc_q;
  logic [PRESC_W-1:0]   presc_d;
  logic                 tick_q;
  logic                 tick_d;
  logic                 clr_q;
  logic                 clr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      freeze_q <= 1'b0;
      presc_q  <= '0;
      tick_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      freeze_q <= freeze_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      clr_q    <= clr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    freeze_d = freeze_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    clr_d    = 1'b0;

    if (key_press[0]) begin
      // Reset event overrides everything else in the same cycle; tick_d
      // stays 0 so tick and clr can never coincide.
      state_d  = ST_IDLE;
      freeze_d = 1'b0;
      presc_d  = '0;
      clr_d    = 1'b1;
    end else begin
      // The prescaler follows the current state, so the cycle in which RUN
      // is left still counts and the cycle in which RUN is entered does not.
      case (state_q)
        ST_RUN: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ST_IDLE: presc_d = '0;
        default: presc_d = presc_q;
      endcase

      if (key_press[1]) begin
        case (state_q)
          ST_IDLE:  state_d = ST_RUN;
          ST_RUN:   state_d = ST_PAUSE;
          ST_PAUSE: state_d = ST_RUN;
          default:  state_d = ST_IDLE;
        endcase
      end

      if (key_press[2] && (state_q != ST_IDLE)) begin
        freeze_d = ~freeze_q;
      end
    end
  end

  assign tick      = tick_q;
  assign clr       = clr_q;
  assign disp_load = ~freeze_q;
  assign state     = state_q;
  assign led       = {(|key_pressed), freeze_q, (state_q == ST_PAUSE), (state_q == ST_RUN)};

endmodule : stopwatch_ctrl

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl with TICK_DIV=4 and
//               DEBOUNCE_CYCLES=3. Key-to-state latency and the glitch
//               expectation follow STOPWATCH_CTRL_DEBOUNCE_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

  localparam int TDIV = 4;
  localparam int DEB  = 3;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int LAT    = 2 + DEB + 1;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit DEB_ON = 1'b0;
`endif
  // Cycles to wait after a tick before pressing so the pause lands with the
  // prescaler holding 2.
  localparam int D_OFF = (2 + 4 * TDIV - LAT) % TDIV;
  localparam int HOLD  = 8;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       k_rst = 1'b1;
  logic       k_start = 1'b1;
  logic       k_disp = 1'b1;
  logic       tick;
  logic       clr;
  logic       disp_load;
  logic [1:0] state;
  logic [3:0] led;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .TICK_DIV       (TDIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_reset       (k_rst),
    .key_start_pause (k_start),
    .key_display_stop(k_disp),
    .tick            (tick),
    .clr             (clr),
    .disp_load       (disp_load),
    .state           (state),
    .led             (led)
  );

  typedef struct {
    logic       p_rst;
    logic       p_start;
    logic       p_disp;
    logic [1:0] st;
    logic       dl;
    logic [3:0] ld;
  } vec_t;

  vec_t tbl[17];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Waits for a tick, then presses start so the FSM pauses with prescaler=2.
  task automatic sync_pause_press(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * TDIV && !seen; i++) begin
      cyc();
      if (tick) seen = 1'b1;
    end
    chk({tag, "_tick_seen"}, 32'(seen), 32'd1);
    repeat (D_OFF) cyc();
    k_start = 1'b0;
    repeat (LAT - 1) cyc();
    chk({tag, "_still_run"}, 32'(state), 32'(S_RUN));
    cyc();
    chk({tag, "_paused"}, 32'(state), 32'(S_PAUSE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt;
    int act;

    //            rst   start disp  state    dl    led
    tbl[0]  = '{1'b0, 1'b0, 1'b0, S_IDLE,  1'b1, 4'b0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, S_IDLE,  1'b1, 4'b1000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, S_IDLE,  1'b1, 4'b0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, S_RUN,   1'b1, 4'b1001};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, S_RUN,   1'b1, 4'b0001};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, S_RUN,   1'b0, 4'b1101};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, S_RUN,   1'b0, 4'b0101};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, S_PAUSE, 1'b0, 4'b1110};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, S_PAUSE, 1'b0, 4'b0110};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, S_PAUSE, 1'b1, 4'b1010};
    tbl[10] = '{1'b0, 1'b0, 1'b0, S_PAUSE, 1'b1, 4'b0010};
    tbl[11] = '{1'b0, 1'b0, 1'b1, S_PAUSE, 1'b0, 4'b1110};
    tbl[12] = '{1'b0, 1'b0, 1'b0, S_PAUSE, 1'b0, 4'b0110};
    tbl[13] = '{1'b0, 1'b1, 1'b0, S_RUN,   1'b0, 4'b1101};
    tbl[14] = '{1'b0, 1'b0, 1'b0, S_RUN,   1'b0, 4'b0101};
    tbl[15] = '{1'b1, 1'b0, 1'b0, S_IDLE,  1'b1, 4'b1000};
    tbl[16] = '{1'b0, 1'b0, 1'b0, S_IDLE,  1'b1, 4'b0000};

    // Reset state
    repeat (3) cyc();
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_clr", 32'(clr), 32'd0);
    chk("rst_disp_load", 32'(disp_load), 32'd1);
    chk("rst_led", 32'(led), 32'd0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Table-driven key sequence
    for (int i = 0; i < 17; i++) begin
      k_rst   = ~tbl[i].p_rst;
      k_start = ~tbl[i].p_start;
      k_disp  = ~tbl[i].p_disp;
      repeat (HOLD) cyc();
      chk($sformatf("tbl[%0d].state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl[%0d].disp_load", i), 32'(disp_load), 32'(tbl[i].dl));
      chk($sformatf("tbl[%0d].led", i), 32'(led), 32'(tbl[i].ld));
    end

    // Start held 20 cycles from IDLE: exact entry latency, tick spacing,
    // single toggle.
    k_start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk($sformatf("hold_state[%0d]", k), 32'(state), (k >= LAT) ? 32'(S_RUN) : 32'(S_IDLE));
      chk($sformatf("hold_tick[%0d]", k), 32'(tick),
          (k > LAT && ((k - LAT) % TDIV) == 0) ? 32'd1 : 32'd0);
    end
    k_start = 1'b1;
    repeat (HOLD) cyc();

    // Pause with prescaler at 2, then resume: next tick after 2 cycles.
    sync_pause_press("pause1");
    k_start = 1'b1;
    nt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (tick) nt++;
    end
    chk("pause_no_tick", 32'(nt), 32'd0);
    chk("pause_state", 32'(state), 32'(S_PAUSE));
    k_start = 1'b0;
    for (int k = 1; k <= LAT + 3; k++) begin
      cyc();
      if (k >= LAT) begin
        chk($sformatf("resume_state[%0d]", k), 32'(state), 32'(S_RUN));
        chk($sformatf("resume_tick[%0d]", k), 32'(tick), (k == LAT + 2) ? 32'd1 : 32'd0);
      end
    end
    k_start = 1'b1;
    repeat (HOLD) cyc();

    // Pause again with a partial interval and the display frozen, then
    // reset and start pressed together.
    sync_pause_press("pause2");
    k_start = 1'b1;
    repeat (HOLD) cyc();
    k_disp = 1'b0;
    repeat (HOLD) cyc();
    chk("pause_freeze_dl", 32'(disp_load), 32'd0);
    k_disp = 1'b1;
    repeat (HOLD) cyc();
    k_rst   = 1'b0;
    k_start = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      cyc();
      chk($sformatf("rstev_tick[%0d]", k), 32'(tick), 32'd0);
      chk($sformatf("rstev_clr[%0d]", k), 32'(clr), (k == LAT) ? 32'd1 : 32'd0);
      chk($sformatf("rstev_state[%0d]", k), 32'(state), (k >= LAT) ? 32'(S_IDLE) : 32'(S_PAUSE));
    end
    chk("rstev_disp_load", 32'(disp_load), 32'd1);
    chk("rstev_led_frozen", 32'(led[2]), 32'd0);
    k_rst   = 1'b1;
    k_start = 1'b1;
    repeat (HOLD) cyc();
    chk("rstev_release_state", 32'(state), 32'(S_IDLE));

    // Prescaler was cleared: first tick a full interval after RUN entry.
    k_start = 1'b0;
    for (int k = 1; k <= LAT + TDIV; k++) begin
      cyc();
      chk($sformatf("presc0_tick[%0d]", k), 32'(tick), (k == LAT + TDIV) ? 32'd1 : 32'd0);
    end
    chk("presc0_state", 32'(state), 32'(S_RUN));
    k_start = 1'b1;
    repeat (HOLD) cyc();

    // Asynchronous rst_n mid-run
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'(S_IDLE));
    chk("async_rst_tick", 32'(tick), 32'd0);
    chk("async_rst_clr", 32'(clr), 32'd0);
    chk("async_rst_disp_load", 32'(disp_load), 32'd1);
    chk("async_rst_led", 32'(led), 32'd0);
    cyc();
    rst_n = 1'b1;
    act = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (state != S_IDLE || tick || clr) act++;
    end
    chk("post_rst_quiet", 32'(act), 32'd0);

    // Two-cycle glitch on start
    k_start = 1'b0;
    cyc();
    cyc();
    k_start = 1'b1;
    cyc();
    chk("glitch_state_k3", 32'(state), DEB_ON ? 32'(S_IDLE) : 32'(S_RUN));
    repeat (9) cyc();
    chk("glitch_state_k12", 32'(state), DEB_ON ? 32'(S_IDLE) : 32'(S_RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_stopwatch_ctrl

`default_nettype wire
